// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- 8-bit execute-stage arithmetic/logic unit
//
// Computes a combinational result (add/sub, bit-mask, XOR, shift) or, in
// branch mode, a 0/1 branch decision derived from a forced in1 - in2 compare.
// The status flags {C,V,N,Z} of each cycle's operation are registered and
// presented one cycle later on flags_q.
//
// Ports
//   clk         in   1  system clock, rising edge
//   reset       in   1  synchronous active-high reset (clears flags_q)
//   in1         in   8  operand A
//   in2         in   8  operand B / shift amount / mask source (bit 0)
//   alu_op      in   2  00 add/sub, 01 mask, 10 XOR, 11 shift
//   sub         in   1  alu_op 00: 1 = in1 - in2, 0 = in1 + in2
//   branch      in   1  1 = branch-compare mode (forces subtract)
//   branch_sel  in   2  00 EQ, 01 signed LT, 10 overflow, 11 NE
//   shift_left  in   1  alu_op 11: 1 = left, 0 = logical right
//   out_val     out  8  combinational result or {7'b0, cond}
//   flags_q     out  4  registered {C,V,N,Z} of the previous cycle
//
// Configuration
//   ALU_FLAG_REG_EN  defined   : flag register built, flags_q as above
//                    undefined : no register, flags_q tied to 4'b0000,
//                                clk and reset unused
// ---------------------------------------------------------------------------
module alu (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic [1:0] alu_op,
    input  logic       sub,
    input  logic       branch,
    input  logic [1:0] branch_sel,
    input  logic       shift_left,
    output logic [7:0] out_val,
    output logic [3:0] flags_q
);

    typedef enum logic [1:0] {
        OP_ADDSUB = 2'b00,
        OP_MASK   = 2'b01,
        OP_XOR    = 2'b10,
        OP_SHIFT  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        BR_EQ  = 2'b00,
        BR_LT  = 2'b01,
        BR_OVF = 2'b10,
        BR_NE  = 2'b11
    } br_sel_e;

    // Flag bit positions inside the {C,V,N,Z} vector.
    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    // ------------------------------------------------------------------
    // Arithmetic core: one adder serves add, subtract and branch compare.
    // Subtraction is in1 + ~in2 + 1, so C = 1 means "no borrow".
    // ------------------------------------------------------------------
    logic       sub_eff;
    logic [7:0] b_eff;
    logic [8:0] sum;
    logic       ar_z;
    logic       ar_n;
    logic       ar_v;
    logic       ar_c;

    assign sub_eff = branch | sub;
    assign b_eff   = in2 ^ {8{sub_eff}};
    assign sum     = {1'b0, in1} + {1'b0, b_eff} + {8'b0, sub_eff};

    assign ar_z = (sum[7:0] == 8'h00);
    assign ar_n = sum[7];
    // Signed overflow: both adder inputs share a sign the result does not.
    assign ar_v = (in1[7] == b_eff[7]) && (sum[7] != in1[7]);
    assign ar_c = sum[8];

    // ------------------------------------------------------------------
    // Result and flag selection
    // ------------------------------------------------------------------
    logic       cond;
    logic [3:0] flags_d;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // can leave it unassigned -- that is what keeps latches out.
        out_val = 8'h00;
        cond    = 1'b0;
        flags_d = 4'b0000;

        if (branch) begin
            case (br_sel_e'(branch_sel))
                BR_EQ:  cond = ar_z;
                BR_LT:  cond = ar_n ^ ar_v;
                BR_OVF: cond = ar_v;
                BR_NE:  cond = !ar_z;
            endcase
            out_val = {7'b0, cond};
            flags_d = {ar_c, ar_v, ar_n, ar_z};
        end else begin
            case (alu_op_e'(alu_op))
                OP_ADDSUB: out_val = sum[7:0];
                // Only in2[0] selects the mask; the upper bits are ignored.
                OP_MASK:   out_val = in1 & {8{in2[0]}};
                OP_XOR:    out_val = in1 ^ in2;
                // Full 8-bit shift amount: anything >= 8 shifts out to zero.
                OP_SHIFT:  out_val = shift_left ? (in1 << in2) : (in1 >> in2);
            endcase

            if (alu_op_e'(alu_op) == OP_ADDSUB) begin
                flags_d = {ar_c, ar_v, ar_n, ar_z};
            end else begin
                flags_d[FLAG_C] = 1'b0;
                flags_d[FLAG_V] = 1'b0;
                flags_d[FLAG_N] = out_val[7];
                flags_d[FLAG_Z] = (out_val == 8'h00);
            end
        end
    end

    // ------------------------------------------------------------------
    // Flag register
    // ------------------------------------------------------------------
`ifdef ALU_FLAG_REG_EN
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment for state so every flop samples the
        // pre-edge values regardless of block evaluation order.
        if (reset) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end
`else
    // No register in this build: flags are computed but not observable.
    logic unused_flag_inputs;
    assign unused_flag_inputs = &{1'b0, clk, reset, flags_d};
    assign flags_q            = 4'b0000;
`endif

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu -- directed self-checking bench for alu
//
// Each vector drives the inputs on the falling edge, checks out_val shortly
// after, then checks flags_q just after the next rising edge. Flag
// expectations collapse to 4'b0000 when ALU_FLAG_REG_EN is undefined.
// ---------------------------------------------------------------------------
module tb_alu;

    logic       clk;
    logic       reset;
    logic [7:0] in1;
    logic [7:0] in2;
    logic [1:0] alu_op;
    logic       sub;
    logic       branch;
    logic [1:0] branch_sel;
    logic       shift_left;
    logic [7:0] out_val;
    logic [3:0] flags_q;

    int n_checks = 0;
    int n_errors = 0;

    alu dut (
        .clk        (clk),
        .reset      (reset),
        .in1        (in1),
        .in2        (in2),
        .alu_op     (alu_op),
        .sub        (sub),
        .branch     (branch),
        .branch_sel (branch_sel),
        .shift_left (shift_left),
        .out_val    (out_val),
        .flags_q    (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] fl(input logic [3:0] f);
`ifdef ALU_FLAG_REG_EN
        return f;
`else
        return 4'b0000;
`endif
    endfunction

    // Drive one operation, check the combinational result, then the
    // registered flags after the following rising edge.
    task automatic run_op(input string tag,
                          input logic [1:0] op, input logic sb,
                          input logic br, input logic [1:0] sel,
                          input logic shl,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_out, input logic [3:0] exp_flags);
        @(negedge clk);
        alu_op     = op;
        sub        = sb;
        branch     = br;
        branch_sel = sel;
        shift_left = shl;
        in1        = a;
        in2        = b;
        #1;
        check({tag, " out"}, out_val, exp_out);
        @(posedge clk);
        #1;
        check({tag, " flags"}, {4'b0, flags_q}, {4'b0, fl(exp_flags)});
    endtask

    initial begin
        reset      = 1'b1;
        in1        = 8'h00;
        in2        = 8'h00;
        alu_op     = 2'b00;
        sub        = 1'b0;
        branch     = 1'b0;
        branch_sel = 2'b00;
        shift_left = 1'b0;

        @(posedge clk);
        #1;
        check("reset flags", {4'b0, flags_q}, 8'h00);
        @(negedge clk);
        reset = 1'b0;

        // Arithmetic                 op    sub  br  sel   shl  in1    in2    out    {C,V,N,Z}
        run_op("add 10+15",          2'b00, 0, 0, 2'b00, 0, 8'd10, 8'd15, 8'd25, 4'b0000);
        run_op("sub 20-5",           2'b00, 1, 0, 2'b00, 0, 8'd20, 8'd5,  8'd15, 4'b1000);
        run_op("add FF+01",          2'b00, 0, 0, 2'b00, 0, 8'hFF, 8'h01, 8'h00, 4'b1001);
        run_op("add 7F+01",          2'b00, 0, 0, 2'b00, 0, 8'h7F, 8'h01, 8'h80, 4'b0110);

        // Logic
        run_op("andb AA,01",         2'b01, 0, 0, 2'b00, 0, 8'hAA, 8'h01, 8'hAA, 4'b0010);
        run_op("andb AA,FE",         2'b01, 0, 0, 2'b00, 0, 8'hAA, 8'hFE, 8'h00, 4'b0001);
        run_op("xor F0,AA",          2'b10, 0, 0, 2'b00, 0, 8'hF0, 8'hAA, 8'h5A, 4'b0000);

        // Shifts
        run_op("shl 3<<2",           2'b11, 0, 0, 2'b00, 1, 8'd3,  8'd2,  8'd12, 4'b0000);
        run_op("shr 12>>2",          2'b11, 0, 0, 2'b00, 0, 8'd12, 8'd2,  8'd3,  4'b0000);
        run_op("shr 80>>1",          2'b11, 0, 0, 2'b00, 0, 8'h80, 8'd1,  8'h40, 4'b0000);
        run_op("shl 01<<7",          2'b11, 0, 0, 2'b00, 1, 8'h01, 8'd7,  8'h80, 4'b0010);
        run_op("shl A5<<8",          2'b11, 0, 0, 2'b00, 1, 8'hA5, 8'd8,  8'h00, 4'b0001);
        run_op("shl A5<<9",          2'b11, 0, 0, 2'b00, 1, 8'hA5, 8'd9,  8'h00, 4'b0001);
        run_op("shr A5>>9",          2'b11, 0, 0, 2'b00, 0, 8'hA5, 8'd9,  8'h00, 4'b0001);

        // Branch EQ
        run_op("beq 5,5",            2'b00, 0, 1, 2'b00, 0, 8'd5,  8'd5,  8'd1,  4'b1001);
        run_op("beq 5,4",            2'b00, 0, 1, 2'b00, 0, 8'd5,  8'd4,  8'd0,  4'b1000);

        // Branch signed LT, true cases (alu_op set to XOR to prove it is ignored)
        run_op("blt 10,20",          2'b10, 0, 1, 2'b01, 0, 8'd10, 8'd20, 8'd1,  4'b0010);
        run_op("blt -31,0",          2'b00, 0, 1, 2'b01, 0, 8'hE1, 8'h00, 8'd1,  4'b1010);
        run_op("blt -31,-30",        2'b00, 0, 1, 2'b01, 0, 8'hE1, 8'hE2, 8'd1,  4'b0010);
        run_op("blt -128,127",       2'b00, 0, 1, 2'b01, 0, 8'h80, 8'h7F, 8'd1,  4'b1100);

        // Branch signed LT, false cases
        run_op("blt 127,-128",       2'b00, 0, 1, 2'b01, 0, 8'h7F, 8'h80, 8'd0,  4'b0110);
        run_op("blt 42,42",          2'b00, 0, 1, 2'b01, 0, 8'd42, 8'd42, 8'd0,  4'b1001);
        run_op("blt 0,-3",           2'b00, 0, 1, 2'b01, 0, 8'h00, 8'hFD, 8'd0,  4'b0000);
        run_op("blt -127,-128",      2'b00, 0, 1, 2'b01, 0, 8'h81, 8'h80, 8'd0,  4'b1000);

        // Branch overflow (sub=0 but subtraction is forced) and NE
        run_op("bovf 127,-1",        2'b00, 0, 1, 2'b10, 0, 8'h7F, 8'hFF, 8'd1,  4'b0110);
        run_op("bovf 127,1",         2'b00, 0, 1, 2'b10, 0, 8'h7F, 8'h01, 8'd0,  4'b1000);
        run_op("bne 5,4",            2'b00, 0, 1, 2'b11, 0, 8'd5,  8'd4,  8'd1,  4'b1000);
        run_op("bne 5,5",            2'b00, 0, 1, 2'b11, 0, 8'd5,  8'd5,  8'd0,  4'b1001);

        // Reset mid-sequence: the flags of the cycle under reset are dropped.
        @(negedge clk);
        reset  = 1'b1;
        branch = 1'b0;
        alu_op = 2'b00;
        sub    = 1'b0;
        in1    = 8'hFF;
        in2    = 8'h01;
        #1;
        check("reset out unaffected", out_val, 8'h00);
        @(posedge clk);
        #1;
        check("reset mid flags", {4'b0, flags_q}, 8'h00);
        @(negedge clk);
        reset = 1'b0;

        // First operation after reset: 10 - 20 -> {C0,V0,N1,Z0}
        run_op("post-reset 10-20",   2'b00, 1, 0, 2'b00, 0, 8'd10, 8'd20, 8'hF6, 4'b0010);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
